// File: rtl/fp_add_share_ctrl_pkg.sv
// Shared FP format selectors, width helpers and the default latency of the shared adder.
package fp_add_share_ctrl_pkg;

    typedef enum logic [1:0] {
        FP16 = 2'd0,
        FP32 = 2'd1,
        FP64 = 2'd2
    } fp_format_e;

    localparam int FP_ADD_PIPE_DEPTH = 32'sd3;

    function automatic int get_fp_len(input fp_format_e fmt);
        case (fmt)
            FP16:    return 32'sd16;
            FP32:    return 32'sd32;
            FP64:    return 32'sd64;
            default: return 32'sd32;
        endcase
    endfunction

    function automatic int get_sign_bit(input fp_format_e fmt);
        return get_fp_len(fmt) - 32'sd1;
    endfunction

endpackage

// File: rtl/fp_add_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index at or after rr_ptr, wrapping mod N.
module fp_add_share_ctrl_rr_arbiter #(
    parameter  int N  = 32'sd4,
    localparam int IW = (N > 32'sd1) ? $clog2(N) : 32'sd1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned k);
        logic [IW:0] sum;
        sum = {1'b0, base} + (IW+1)'(k);
        return (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    endfunction

    // Scan farthest-first so the candidate closest to rr_ptr is the one that sticks.
    always_comb begin
        grant_idx   = {IW{1'b0}};
        grant_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            grant_idx   = elig[wrap_idx(rr_ptr, k)] ? wrap_idx(rr_ptr, k) : grant_idx;
            grant_valid = grant_valid | elig[wrap_idx(rr_ptr, k)];
        end
    end

    // One-hot expansion of the selected index.
    always_comb begin
        grant = {N{1'b0}};
        for (int j = 0; j < N; j++) begin
            grant[j] = grant_valid & (grant_idx == IW'(j));
        end
    end

endmodule

// File: rtl/fp_add_share_ctrl.sv
// Shares one fixed-latency pipelined FP adder among NUM_REQ requesters with round-robin issue,
// a tag pipe that follows the adder latency, and per-requester held response slots.
module fp_add_share_ctrl
    import fp_add_share_ctrl_pkg::*;
#(
    parameter  fp_format_e data_format = FP32,
    parameter  int         NUM_REQ     = 32'sd4,
    parameter  int         PIPE_DEPTH  = FP_ADD_PIPE_DEPTH,
    localparam int         W           = get_fp_len(data_format)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_sub,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic                 add_in_valid,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic                 add_out_valid,
    input  logic [W-1:0]         add_sum,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [NUM_REQ*W-1:0] rsp_data,
    output logic [NUM_REQ-1:0]   busy,
    output logic                 err
);

    localparam int SB   = get_sign_bit(data_format);
    localparam int ID_W = (NUM_REQ > 32'sd1) ? $clog2(NUM_REQ) : 32'sd1;

    logic [ID_W-1:0]      rr_ptr_r;
    logic [ID_W-1:0]      rr_ptr_nxt_s;
    logic [NUM_REQ-1:0]   busy_r;
    logic [NUM_REQ-1:0]   elig_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [ID_W-1:0]      grant_idx_s;
    logic                 grant_vld_s;

    logic [W-1:0]         sel_a_s;
    logic [W-1:0]         sel_b_s;
    logic                 sel_sub_s;
    logic [W-1:0]         issue_b_s;

    logic                 add_in_valid_r;
    logic [W-1:0]         add_a_r;
    logic [W-1:0]         add_b_r;
    logic [ID_W-1:0]      add_id_r;

    logic [PIPE_DEPTH-1:0] tag_vld_r;
    logic [ID_W-1:0]       tag_id_r [PIPE_DEPTH];
    logic                  head_vld_s;
    logic [ID_W-1:0]       head_id_s;

    logic [NUM_REQ-1:0]   ret_s;
    logic [NUM_REQ-1:0]   take_s;
    logic [NUM_REQ-1:0]   rsp_valid_r;
    logic [NUM_REQ*W-1:0] rsp_data_r;
    logic                 err_r;

    // A requester with an op in flight or an untaken result cannot be granted again.
    assign elig_s = req_valid & ~busy_r;

    fp_add_share_ctrl_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .elig        (elig_s),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_vld_s)
    );

    // AND-OR operand mux driven by the one-hot grant; subtraction flips the sign of b.
    always_comb begin
        sel_a_s   = {W{1'b0}};
        sel_b_s   = {W{1'b0}};
        sel_sub_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s   = sel_a_s | (req_a[i*W +: W] & {W{grant_s[i]}});
            sel_b_s   = sel_b_s | (req_b[i*W +: W] & {W{grant_s[i]}});
            sel_sub_s = sel_sub_s | (req_sub[i] & grant_s[i]);
        end
        issue_b_s = {sel_b_s[SB] ^ sel_sub_s, sel_b_s[SB-1:0]};
    end

    // Pointer advances to the slot after the winner, wrapping at NUM_REQ.
    always_comb begin
        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_nxt_s = {ID_W{1'b0}};
        end else begin
            rr_ptr_nxt_s = grant_idx_s + ID_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= {ID_W{1'b0}};
        end else if (grant_vld_s) begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Registered issue to the adder; operands hold while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_in_valid_r <= 1'b0;
            add_a_r        <= {W{1'b0}};
            add_b_r        <= {W{1'b0}};
            add_id_r       <= {ID_W{1'b0}};
        end else if (grant_vld_s) begin
            add_in_valid_r <= 1'b1;
            add_a_r        <= sel_a_s;
            add_b_r        <= issue_b_s;
            add_id_r       <= grant_idx_s;
        end else begin
            add_in_valid_r <= 1'b0;
            add_a_r        <= add_a_r;
            add_b_r        <= add_b_r;
            add_id_r       <= add_id_r;
        end
    end

    // Tag pipe enters as the adder captures its inputs, so its head lines up with add_out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_r <= {PIPE_DEPTH{1'b0}};
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                tag_id_r[k] <= {ID_W{1'b0}};
            end
        end else begin
            tag_vld_r[0] <= add_in_valid_r;
            tag_id_r[0]  <= add_id_r;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1];
                tag_id_r[k]  <= tag_id_r[k-1];
            end
        end
    end

    assign head_vld_s = tag_vld_r[PIPE_DEPTH-1];
    assign head_id_s  = tag_id_r[PIPE_DEPTH-1];

    // A result is only accepted when both the adder and the tag head agree it is valid.
    always_comb begin
        ret_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            ret_s[i] = head_vld_s & add_out_valid & (head_id_s == ID_W'(i));
        end
        take_s = rsp_valid_r & rsp_ready;
    end

    // Per-requester busy flag and held response slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r      <= {NUM_REQ{1'b0}};
            rsp_valid_r <= {NUM_REQ{1'b0}};
            rsp_data_r  <= {(NUM_REQ*W){1'b0}};
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s[i]) begin
                    busy_r[i] <= 1'b1;
                end else if (take_s[i]) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end

                if (ret_s[i]) begin
                    rsp_valid_r[i]       <= 1'b1;
                    rsp_data_r[i*W +: W] <= add_sum;
                end else if (take_s[i]) begin
                    rsp_valid_r[i]       <= 1'b0;
                    rsp_data_r[i*W +: W] <= rsp_data_r[i*W +: W];
                end else begin
                    rsp_valid_r[i]       <= rsp_valid_r[i];
                    rsp_data_r[i*W +: W] <= rsp_data_r[i*W +: W];
                end
            end
        end
    end

    // Sticky flag for any disagreement between adder output strobe and tag head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (add_out_valid != head_vld_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign req_ready    = grant_s;
    assign add_in_valid = add_in_valid_r;
    assign add_a        = add_a_r;
    assign add_b        = add_b_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign busy         = busy_r;
    assign err          = err_r;

endmodule

// File: tb/tb_fp_add_share_ctrl.sv
// Bench for fp_add_share_ctrl: directed vector table, multi-cycle corner sequences and a
// cycle-timestamp reference model driven by random stimulus, with an ideal 3-cycle FP32 adder.
module tb_fp_add_share_ctrl;
    import fp_add_share_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int PD = 3;
    localparam int W  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_sub, rsp_valid, rsp_ready, busy;
    logic [N*W-1:0] req_a, req_b, rsp_data;
    logic           add_in_valid, add_out_valid, err;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           force_ov;

    int n_cmp = 0;
    int n_err = 0;
    int glog[$];

    fp_add_share_ctrl #(
        .data_format (FP32),
        .NUM_REQ     (N),
        .PIPE_DEPTH  (PD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sub       (req_sub),
        .req_a         (req_a),
        .req_b         (req_b),
        .add_in_valid  (add_in_valid),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_out_valid (add_out_valid),
        .add_sum       (add_sum),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .err           (err)
    );

    function automatic real fp32_to_real(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_fp32(input real r);
        logic [63:0] d;
        int          ex;
        if (r == 0.0) return 32'h0;
        d  = $realtobits(r);
        ex = int'(d[62:52]) - 896;
        return {d[63], ex[7:0], d[51:29]};
    endfunction

    // Operands are small integers, so the FP32 sum is exact.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
    endfunction

    // Ideal adder with PD-cycle latency, sharing rst_n with the controller.
    logic [PD-1:0] am_vld;
    logic [W-1:0]  am_sum [PD];
    always @(posedge clk) begin
        if (!rst_n) begin
            am_vld <= '0;
        end else begin
            am_vld    <= {am_vld[PD-2:0], add_in_valid};
            am_sum[0] <= fp_add(add_a, add_b);
            for (int k = 1; k < PD; k++) am_sum[k] <= am_sum[k-1];
        end
    end
    assign add_out_valid = am_vld[PD-1] | force_ov;
    assign add_sum       = am_sum[PD-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_sub   = '0;
        rsp_ready = '0;
        force_ov  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_add_in_valid"}, add_in_valid, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_add_a"}, add_a, 0);
        check({tag, "_add_b"}, add_b, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    // mode 0: random traffic, 1: all valid / all ready, 2: all valid / rsp_ready[1] held low.
    task automatic run_model(input int cycles, input int mode);
        logic         m_busy [N];
        int           m_due [N];
        logic [31:0]  m_res [N];
        logic         exp_iv;
        logic [31:0]  exp_a, exp_b, ba;
        logic [N-1:0] exp_rdy, exp_rv, exp_busy;
        int           ptr, g, idx, v;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_due[i]  = 0;
            m_res[i]  = 32'h0;
        end
        ptr = 0; exp_iv = 1'b0; exp_a = 32'h0; exp_b = 32'h0;
        glog.delete();
        for (int c = 0; c < cycles; c++) begin
            case (mode)
                0:       begin req_valid = 4'($urandom) | 4'($urandom); rsp_ready = 4'($urandom); end
                1:       begin req_valid = 4'b1111; rsp_ready = 4'b1111; end
                default: begin req_valid = 4'b1111; rsp_ready = 4'b1101; end
            endcase
            for (int i = 0; i < N; i++) begin
                v = int'($urandom_range(2000)) - 1000;
                req_a[i*W +: W] = real_to_fp32(real'(v));
                v = int'($urandom_range(2000)) - 1000;
                req_b[i*W +: W] = real_to_fp32(real'(v));
                req_sub[i] = 1'($urandom);
            end
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (g < 0 && req_valid[idx] && !m_busy[idx]) g = idx;
            end
            exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            for (int i = 0; i < N; i++) begin
                exp_rv[i]   = m_busy[i] && (c >= m_due[i]);
                exp_busy[i] = m_busy[i];
            end
            check("req_ready", req_ready, exp_rdy);
            check("add_in_valid", add_in_valid, exp_iv);
            if (exp_iv) begin
                check("add_a", add_a, exp_a);
                check("add_b", add_b, exp_b);
            end
            check("rsp_valid", rsp_valid, exp_rv);
            for (int i = 0; i < N; i++) begin
                if (exp_rv[i]) check("rsp_data", rsp_data[i*W +: W], m_res[i]);
            end
            check("busy", busy, exp_busy);
            check("err_quiet", err, 0);
            for (int i = 0; i < N; i++) begin
                if (exp_rv[i] && rsp_ready[i]) m_busy[i] = 1'b0;
            end
            if (g >= 0) begin
                ba        = req_b[g*W +: W];
                exp_a     = req_a[g*W +: W];
                exp_b     = {ba[31] ^ req_sub[g], ba[30:0]};
                exp_iv    = 1'b1;
                m_busy[g] = 1'b1;
                m_due[g]  = c + 2 + PD;
                m_res[g]  = fp_add(exp_a, exp_b);
                ptr       = (g + 1) % N;
                glog.push_back(g);
            end else begin
                exp_iv = 1'b0;
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_b;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t         vecs[4];
    logic [N-1:0] oh;
    int           cnt [N];
    int           got;
    logic         late;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_sub = '0; rsp_ready = '0; force_ov = 1'b0;
        req_a = '0; req_b = '0;
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000};
        vecs[1] = '{2, 32'h3F800000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h00000000};
        vecs[2] = '{1, 32'h40400000, 32'hC0000000, 1'b0, 32'hC0000000, 32'h3F800000};
        vecs[3] = '{3, 32'h41200000, 32'h40A00000, 1'b1, 32'hC0A00000, 32'h40A00000};
        @(negedge clk);

        do_reset();
        check_all_zero("reset");

        // Directed single ops: grant at t, issue at t+1, response at t+5.
        for (int n = 0; n < 4; n++) begin
            oh = 4'b0001 << vecs[n].id;
            req_valid = oh;
            req_sub[vecs[n].id] = vecs[n].sub;
            req_a[vecs[n].id*W +: W] = vecs[n].a;
            req_b[vecs[n].id*W +: W] = vecs[n].b;
            #1;
            check("vec_ready", req_ready, oh);
            tick();
            req_valid = '0;
            check("vec_issue_valid", add_in_valid, 1);
            check("vec_add_a", add_a, vecs[n].a);
            check("vec_add_b", add_b, vecs[n].exp_b);
            check("vec_busy", busy, oh);
            tick(); tick(); tick();
            check("vec_rsp_early", rsp_valid, 0);
            tick();
            check("vec_rsp_valid", rsp_valid, oh);
            check("vec_rsp_data", rsp_data[vecs[n].id*W +: W], vecs[n].exp_sum);
            rsp_ready = oh;
            tick();
            rsp_ready = '0;
            check("vec_rsp_clear", rsp_valid, 0);
            check("vec_busy_clear", busy, 0);
        end

        // All four valid, all ready: fair rotation starting at req0.
        do_reset();
        run_model(24, 1);
        for (int j = 0; j < 4; j++) begin
            got = (j < glog.size()) ? glog[j] : -1;
            check("rr_order", got, j);
        end
        for (int i = 0; i < N; i++) cnt[i] = 0;
        foreach (glog[j]) cnt[glog[j]]++;
        for (int i = 0; i < N; i++) check("no_starve", cnt[i] >= 2, 1);

        // Requester 1 withholds rsp_ready: its slot holds, others keep issuing.
        do_reset();
        run_model(20, 2);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        foreach (glog[j]) cnt[glog[j]]++;
        check("hold_req1_grants", cnt[1], 1);
        check("hold_req0_issues", cnt[0] >= 2, 1);

        // Random traffic against the reference model.
        do_reset();
        run_model(400, 0);

        // Adder strobe with an empty tag pipe.
        do_reset();
        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
        check("err_set", err, 1);
        check("err_no_rsp", rsp_valid, 0);
        tick(); tick(); tick(); tick(); tick();
        check("err_sticky", err, 1);
        check("err_no_rsp_late", rsp_valid, 0);

        // Reset with three ops in flight.
        do_reset();
        req_valid = 4'b0111;
        tick(); tick(); tick();
        req_valid = '0;
        check("inflight_busy", busy, 4'b0111);
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_n = 1'b1;
        late = 1'b0;
        for (int c = 0; c < 10; c++) begin
            late = late | (|rsp_valid);
            tick();
        end
        check("no_late_rsp", late, 0);
        req_valid = 4'b1111;
        #1;
        check("post_reset_ptr", req_ready, 4'b0001);
        req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
